cpu: RTL and testbench

- Minimal 8-bit accumulator CPU.
- Executes one instruction per clock from an internal 16-word program ROM set by a parameter.
- Drives a registered 8-bit output port `value`, which the top level monitors.
- Self-contained: no external memory or bus. Used as the core demo/bring-up block.

---
 rtl/cpu.sv | 112 +++++++++++
 tb/tb_cpu.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: single-cycle 8-bit accumulator core executing from a 16-word ROM held in PROG.
// Build option CPU_HALT_EN: op F halts the core until reset; without it op F is a NOP.
module cpu #(
    parameter logic [127:0] PROG = 128'h0000_0000_0000_0000_0000_0000_B131_A010
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDH  = 4'h2,
        OP_ADDI = 4'h3,
        OP_SUBI = 4'h4,
        OP_ANDI = 4'h5,
        OP_ORI  = 4'h6,
        OP_XORI = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_OUT  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_JNZ  = 4'hD,
        OP_RSV  = 4'hE,
        OP_HALT = 4'hF
    } op_t;

    logic [3:0] pc, pc_nxt;
    logic [7:0] acc, acc_nxt;
    logic [7:0] value_nxt;
    logic       z, z_nxt;
    logic       acc_wr;
    logic [7:0] instr;
    op_t        op;
    logic [3:0] imm;

    assign instr = PROG[{pc, 3'b000} +: 8];
    assign op    = op_t'(instr[7:4]);
    assign imm   = instr[3:0];

`ifdef CPU_HALT_EN
    // state   | meaning
    // S_RUN   | fetching and executing one instruction per edge
    // S_HALT  | HALT executed; all architectural state frozen until reset
    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nxt;
    end
`endif

    always_comb begin
        pc_nxt    = pc + 4'd1;
        acc_nxt   = acc;
        z_nxt     = z;
        value_nxt = value;
        acc_wr    = 1'b0;
`ifdef CPU_HALT_EN
        state_nxt = state;
`endif
        case (op)
            OP_LDI:  begin acc_nxt = {4'h0, imm};          acc_wr = 1'b1; end
            OP_LDH:  begin acc_nxt = {imm, acc[3:0]};      acc_wr = 1'b1; end
            OP_ADDI: begin acc_nxt = acc + {4'h0, imm};    acc_wr = 1'b1; end
            OP_SUBI: begin acc_nxt = acc - {4'h0, imm};    acc_wr = 1'b1; end
            OP_ANDI: begin acc_nxt = acc & {4'h0, imm};    acc_wr = 1'b1; end
            OP_ORI:  begin acc_nxt = acc | {4'h0, imm};    acc_wr = 1'b1; end
            OP_XORI: begin acc_nxt = acc ^ {4'h0, imm};    acc_wr = 1'b1; end
            OP_SHL:  begin acc_nxt = {acc[6:0], 1'b0};     acc_wr = 1'b1; end
            OP_SHR:  begin acc_nxt = {1'b0, acc[7:1]};     acc_wr = 1'b1; end
            OP_OUT:  value_nxt = acc;
            OP_JMP:  pc_nxt = imm;
            OP_JZ:   if (z)  pc_nxt = imm;
            OP_JNZ:  if (!z) pc_nxt = imm;
`ifdef CPU_HALT_EN
            OP_HALT: begin
                pc_nxt    = pc;
                state_nxt = S_HALT;
            end
`endif
            default: ;
        endcase
        if (acc_wr) z_nxt = (acc_nxt == 8'h00);
`ifdef CPU_HALT_EN
        // Once halted nothing moves, regardless of the ROM word under pc.
        if (state == S_HALT) begin
            pc_nxt    = pc;
            acc_nxt   = acc;
            z_nxt     = z;
            value_nxt = value;
            state_nxt = S_HALT;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= 4'h0;
            acc   <= 8'h00;
            z     <= 1'b1;
            value <= 8'h00;
        end else begin
            pc    <= pc_nxt;
            acc   <= acc_nxt;
            z     <= z_nxt;
            value <= value_nxt;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: several cpu instances with different ROMs; expected port values are queued
// at reset release and compared against the matching instance at the given edge.
module tb_cpu;
    localparam logic [127:0] P_ARITH = 128'h000000BC_A013CBA0_802818A0_80A04110;
    localparam logic [127:0] P_BR    = 128'h00000000_00000000_000000B4_A0D14112;
    localparam logic [127:0] P_BR2   = 128'h00000000_00000000_0000B5A0_37D14112;
    localparam logic [127:0] P_MISC  = 128'hA043A0DE_3FE0A02F_905D756C_A011C410;
    localparam logic [127:0] P_HALT  = 128'h00000000_00000000_0000B5A0_19F0A015;

`ifdef CPU_HALT_EN
    localparam logic [7:0] HALT_LATE = 8'h05;
`else
    localparam logic [7:0] HALT_LATE = 8'h09;
`endif

    logic       clk;
    logic       rst_def, rst_aux;
    logic [7:0] v_def, v_ar, v_br, v_br2, v_misc, v_halt;

    cpu u_def                      (.clk(clk), .reset(rst_def), .value(v_def));
    cpu #(.PROG(P_ARITH)) u_arith  (.clk(clk), .reset(rst_aux), .value(v_ar));
    cpu #(.PROG(P_BR))    u_br     (.clk(clk), .reset(rst_aux), .value(v_br));
    cpu #(.PROG(P_BR2))   u_br2    (.clk(clk), .reset(rst_aux), .value(v_br2));
    cpu #(.PROG(P_MISC))  u_misc   (.clk(clk), .reset(rst_aux), .value(v_misc));
    cpu #(.PROG(P_HALT))  u_halt   (.clk(clk), .reset(rst_aux), .value(v_halt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         unit;
        int         cyc;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[21];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [7:0] unit_val(input int u);
        case (u)
            0:       return v_ar;
            1:       return v_br;
            2:       return v_br2;
            3:       return v_misc;
            4:       return v_halt;
            default: return v_def;
        endcase
    endfunction

    function automatic string unit_name(input int u);
        case (u)
            0:       return "arith";
            1:       return "branch";
            2:       return "branch_jnz";
            3:       return "misc";
            4:       return "halt";
            default: return "default_prog";
        endcase
    endfunction

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: value=%02h expected %02h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input int u, input int c, input logic [7:0] e);
        vec_t v;
        v.unit = u;
        v.cyc  = c;
        v.exp  = e;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(0, 3,  8'hFF);
        tbl[1]  = mk(0, 4,  8'hFF);
        tbl[2]  = mk(0, 5,  8'hFE);
        tbl[3]  = mk(0, 9,  8'h10);
        tbl[4]  = mk(0, 11, 8'h10);
        tbl[5]  = mk(0, 12, 8'h03);
        tbl[6]  = mk(0, 20, 8'h03);
        tbl[7]  = mk(1, 6,  8'h00);
        tbl[8]  = mk(1, 20, 8'h00);
        tbl[9]  = mk(2, 5,  8'h00);
        tbl[10] = mk(2, 7,  8'h07);
        tbl[11] = mk(2, 20, 8'h07);
        tbl[12] = mk(3, 7,  8'h00);
        tbl[13] = mk(3, 8,  8'hF4);
        tbl[14] = mk(3, 12, 8'hF4);
        tbl[15] = mk(3, 13, 8'h00);
        tbl[16] = mk(3, 20, 8'h00);
        tbl[17] = mk(3, 21, 8'hF4);
        tbl[18] = mk(4, 2,  8'h05);
        tbl[19] = mk(4, 5,  HALT_LATE);
        tbl[20] = mk(4, 20, HALT_LATE);

        rst_def = 1'b0;
        rst_aux = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            chk("reset_hold", e, v_def, 8'h00);
        end

        @(negedge clk);
        rst_def = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk); #1;
            if (e % 3 == 2) chk("release_step", e, v_def, 8'((e - 2) / 3));
        end

        @(negedge clk);
        rst_def = 1'b0;
        #1;
        chk("async_reset", 0, v_def, 8'h00);
        for (int e = 1; e <= 2; e++) begin
            @(posedge clk); #1;
            chk("async_hold", e, v_def, 8'h00);
        end

        @(negedge clk);
        rst_def = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            if (e == 2) chk("restart_e2", e, v_def, 8'h00);
            if (e == 5) chk("restart_e5", e, v_def, 8'h01);
        end

        @(negedge clk);
        rst_def = 1'b0;
        @(negedge clk);
        foreach (tbl[i]) sb.push_back(tbl[i]);
        for (int n = 0; n < 256; n++) sb.push_back(mk(5, 3 * n + 2, 8'(n)));
        sb.push_back(mk(5, 769, 8'hFF));
        sb.push_back(mk(5, 770, 8'h00));
        rst_def = 1'b1;
        rst_aux = 1'b1;

        for (int e = 1; e <= 775; e++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == e) begin
                    chk(unit_name(sb[i].unit), e, unit_val(sb[i].unit), sb[i].exp);
                    sb.delete(i);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
